// File: rtl/dec_queue.sv
// -----------------------------------------------------------------------------
// dec_queue
//
// Decoupling queue between the decode unit and issue. Buffers up to DEPTH
// packed decoded-instruction bundles so fetch/decode can keep running while
// issue stalls. All status outputs (in_ready, out_valid, almost_full) are
// decoded from the registered occupancy count, so there is no combinational
// path from out_ready back to in_ready.
//
// Parameters
//   DW     width of one packed bundle
//   DEPTH  number of entries (power of two, >= 2)
//   AFULL  almost_full threshold, 1 <= AFULL <= DEPTH
//   CW     width of count (derived)
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   pipe_flush   in   1      discard all entries and any same-cycle push/pop
//   in_data      in   DW     bundle from decode
//   in_valid     in   1      in_data valid
//   in_ready     out  1      queue can accept (count < DEPTH)
//   out_data     out  DW     head-of-queue bundle
//   out_valid    out  1      head entry valid (count != 0)
//   out_ready    in   1      issue accepts the head this cycle
//   count        out  CW     entries currently held, 0..DEPTH
//   almost_full  out  1      count >= AFULL
// -----------------------------------------------------------------------------
module dec_queue #(
    parameter int DW    = 200,
    parameter int DEPTH = 4,
    parameter int AFULL = 3,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pipe_flush,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          almost_full
);

    // DEPTH is a power of two, so pointers wrap naturally at AW bits.
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic push;
    logic pop;
    logic do_push;
    logic do_pop;

    // Status is a pure decode of the registered count.
    assign in_ready    = (count_q != CW'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign almost_full = (count_q >= CW'(AFULL));
    assign count       = count_q;

    // Head is read straight out of the register array; no bypass from in_data.
    assign out_data = mem[rd_ptr];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // A flush swallows any handshake that happens in the same cycle.
    assign do_push = push & ~pipe_flush;
    assign do_pop  = pop & ~pipe_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (pipe_flush) begin
            wr_ptr <= '0;
        end else if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
        end
    end

    // Popped entries are left in place; only the read pointer moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pipe_flush) begin
            rd_ptr <= '0;
        end else if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (pipe_flush) begin
            count_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_queue.sv
module tb_dec_queue;

    localparam int DW    = 200;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          pipe_flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          almost_full;

    dec_queue #(.DW(DW), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_flush  (pipe_flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: bundles held by the queue, oldest first. A push chosen
    // by the stimulus is appended immediately and flagged pending until the
    // clock edge that commits it has been accounted for by the monitor.
    logic [DW-1:0] exp_q [$];
    bit            pend_push = 1'b0;
    bit            mon_en    = 1'b0;

    function automatic void chk(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] rnd_bundle();
        logic [DW-1:0] b;
        b = '0;
        for (int i = 0; i < (DW + 31) / 32; i++) begin
            b = (b << 32) | DW'($urandom);
        end
        return b;
    endfunction

    // Drive one cycle of stimulus shortly after the rising edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_data    = d;
        out_ready  = r;
        pipe_flush = f;
        if (!f && v && exp_q.size() < DEPTH) begin
            exp_q.push_back(d);
            pend_push = 1'b1;
        end
    endtask

    // Monitor: compare registered state with the model, then retire the
    // head if issue takes it on the coming edge.
    always @(negedge clk) begin
        int exp_cnt;
        logic [DW-1:0] head;
        if (mon_en) begin
            exp_cnt = exp_q.size() - (pend_push ? 1 : 0);
            chk("count", DW'(count), DW'(exp_cnt));
            chk("count_bound", DW'(count <= CW'(DEPTH)), DW'(1));
            chk("in_ready", DW'(in_ready), DW'(exp_cnt < DEPTH));
            chk("out_valid", DW'(out_valid), DW'(exp_cnt != 0));
            chk("almost_full", DW'(almost_full), DW'(exp_cnt >= AFULL));
            if (pipe_flush) begin
                exp_q.delete();
            end else if (out_ready && exp_cnt > 0) begin
                head = exp_q.pop_front();
                chk("out_data", out_data, head);
            end
            pend_push = 1'b0;
        end
    end

    logic [DW-1:0] x_val;

    initial begin
        rst_n      = 1'b0;
        pipe_flush = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;

        // Reset state, before any clock edge.
        #2;
        chk("rst_count", DW'(count), DW'(0));
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_out_data", out_data, DW'(0));
        chk("rst_afull", DW'(almost_full), DW'(0));
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Fill: four pushes, then a fifth offered while full.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(32'hA0 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("fill_count", DW'(count), DW'(DEPTH));
        chk("fill_in_ready", DW'(in_ready), DW'(0));
        chk("fill_afull", DW'(almost_full), DW'(1));

        // Drain in order.
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("drain_out_valid", DW'(out_valid), DW'(0));

        // Streaming through the wrap point.
        for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("stream_empty", DW'(count), DW'(0));

        // Flush with simultaneous push and pop.
        for (int i = 0; i < 3; i++) step(1'b1, rnd_bundle(), 1'b0, 1'b0);
        step(1'b1, rnd_bundle(), 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("flush_count", DW'(count), DW'(0));
        chk("flush_out_valid", DW'(out_valid), DW'(0));
        x_val = rnd_bundle();
        step(1'b1, x_val, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("after_flush_count", DW'(count), DW'(1));
        chk("after_flush_head", out_data, x_val);

        // Asynchronous reset in the middle of a cycle.
        step(1'b1, rnd_bundle(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_count", DW'(count), DW'(0));
        chk("mid_rst_in_ready", DW'(in_ready), DW'(1));
        chk("mid_rst_out_valid", DW'(out_valid), DW'(0));
        chk("mid_rst_out_data", out_data, DW'(0));
        exp_q.delete();
        pend_push  = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        pipe_flush = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Random traffic with shifting bias.
        for (int i = 0; i < 20000; i++) begin
            int pv;
            int pr;
            pv = (i / 2000) % 3;
            pr = (i / 3000) % 3;
            step($urandom_range(0, 3) > pv, rnd_bundle(),
                 $urandom_range(0, 3) > pr, $urandom_range(0, 63) == 0);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
